branch_fetch_sequencer: RTL

//  Program-counter sequencer around the branch/jump target adder. Owns the PC

---
 rtl/branch_fetch_if.sv | 33 +++
 rtl/branch_fetch_sequencer.sv | 101 ++++++++++
 2 files changed

// File: rtl/branch_fetch_if.sv
// Decode / instruction-memory bundle for the branch fetch sequencer.
// Valid/ready handshake: imem_req is the valid and imem_ack the ready; a fetch
// completes in a cycle where both are high and ack is meaningless when req is low.
interface branch_fetch_if #(
    parameter int INST_1_WIDTH    = 8,
    parameter int INST_2_WIDTH    = 12,
    parameter int INST_ADDR_WIDTH = 16,
    parameter int CNT_WIDTH       = 8
);
    logic                       redirect_valid;
    logic                       jump;
    logic [INST_1_WIDTH-1:0]    inst_1;
    logic [INST_2_WIDTH-1:0]    inst_2;
    logic [INST_ADDR_WIDTH-1:0] br_pc;
    logic                       stall;
    logic                       imem_req;
    logic [INST_ADDR_WIDTH-1:0] imem_addr;
    logic                       imem_ack;
    logic                       fetch_valid;
    logic [INST_ADDR_WIDTH-1:0] fetch_pc;
    logic                       flush;
    logic [CNT_WIDTH-1:0]       redirect_cnt;

    modport master (
        input  redirect_valid, jump, inst_1, inst_2, br_pc, stall, imem_ack,
        output imem_req, imem_addr, fetch_valid, fetch_pc, flush, redirect_cnt
    );

    modport slave (
        output redirect_valid, jump, inst_1, inst_2, br_pc, stall, imem_ack,
        input  imem_req, imem_addr, fetch_valid, fetch_pc, flush, redirect_cnt
    );
endinterface

// File: rtl/branch_fetch_sequencer.sv
// PC sequencer: owns the PC, issues fetches, applies branch/jump redirects
// with a one-cycle flush, and stalls on decode back-pressure.
module branch_fetch_sequencer #(
    parameter int                   INST_1_WIDTH    = 8,
    parameter int                   INST_2_WIDTH    = 12,
    parameter int                   INST_ADDR_WIDTH = 16,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter int                   CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_fetch_if.master       bus,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        HOLD     = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t                     state, state_next;
    logic [INST_ADDR_WIDTH-1:0] pc, pc_next;
    logic                       req, req_next;
    logic                       fv, fv_next;
    logic [INST_ADDR_WIDTH-1:0] fpc, fpc_next;
    logic                       flush_q, flush_next;
    logic [CNT_WIDTH-1:0]       cnt, cnt_next;
    logic [INST_ADDR_WIDTH-1:0] target;

    // Offsets are unsigned; the sum wraps modulo 2^INST_ADDR_WIDTH.
    assign target = bus.jump ? bus.br_pc + INST_ADDR_WIDTH'(bus.inst_2)
                             : bus.br_pc + INST_ADDR_WIDTH'(bus.inst_1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            req     <= 1'b0;
            fv      <= 1'b0;
            fpc     <= '0;
            flush_q <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            req     <= req_next;
            fv      <= fv_next;
            fpc     <= fpc_next;
            flush_q <= flush_next;
            cnt     <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        req_next   = 1'b0;
        fv_next    = 1'b0;
        fpc_next   = fpc;
        flush_next = 1'b0;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                state_next = FETCH;
                req_next   = 1'b1;
            end
            FETCH, HOLD, REDIRECT: begin
                // Priority: redirect over stall over ack; an ack lost here is re-fetched.
                if (bus.redirect_valid) begin
                    state_next = REDIRECT;
                    pc_next    = target;
                    flush_next = 1'b1;
                    if (cnt != {CNT_WIDTH{1'b1}}) cnt_next = cnt + 1'b1;
                end else if (state == REDIRECT) begin
                    state_next = FETCH;
                    req_next   = 1'b1;
                end else if (bus.stall) begin
                    state_next = HOLD;
                end else begin
                    state_next = FETCH;
                    req_next   = 1'b1;
                    if (state == FETCH && bus.imem_ack) begin
                        fv_next  = 1'b1;
                        fpc_next = pc;
                        pc_next  = pc + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.imem_req     = req;
    assign bus.imem_addr    = pc;
    assign bus.fetch_valid  = fv;
    assign bus.fetch_pc     = fpc;
    assign bus.flush        = flush_q;
    assign bus.redirect_cnt = cnt;
    assign state_dbg        = state;
endmodule
